// File: rtl/clb_config_loader.sv
// Configuration sequencer: streams NUM_CLB programming words into shadow storage and commits them
// atomically to the CLB array. Optional odd-parity checking is enabled by defining CLB_CFG_PARITY_EN.
module clb_config_loader #(
  parameter int unsigned NUM_CLB = 4,
  parameter int unsigned PROG_W  = 17,
  parameter int unsigned CNT_W   = $clog2(NUM_CLB + 1)
) (
  input  logic                      clb_clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic [PROG_W-1:0]         cfg_data,
  input  logic                      cfg_valid,
`ifdef CLB_CFG_PARITY_EN
  input  logic                      cfg_parity,
`endif
  output logic                      cfg_ready,
  output logic [CNT_W-1:0]          cfg_count,
  output logic [NUM_CLB*PROG_W-1:0] prog_bus,
  output logic                      clb_run,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [NUM_CLB-1:0][PROG_W-1:0] shadow;
  logic xfer;
  logic word_ok;
  logic bad_word;
  logic last_word;
  logic start_load;

`ifdef CLB_CFG_PARITY_EN
  assign word_ok = ^{cfg_parity, cfg_data};
`else
  assign word_ok = 1'b1;
`endif

  // Abort suppresses any transfer in the same cycle, including the final word.
  assign xfer       = (state == LOAD) && cfg_valid && !cfg_abort;
  assign bad_word   = xfer && !word_ok;
  assign last_word  = (cfg_count == CNT_W'(NUM_CLB - 1));
  assign start_load = ((state == IDLE) || (state == RUN)) && cfg_start;

  assign cfg_ready = (state == LOAD);
  assign cfg_busy  = (state == LOAD) || (state == COMMIT);
  assign cfg_done  = (state == RUN);
  assign clb_run   = (state == RUN);

  always_ff @(posedge clb_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_start) state_next = LOAD;
      LOAD: begin
        if (cfg_abort || bad_word)   state_next = IDLE;
        else if (xfer && last_word)  state_next = COMMIT;
      end
      COMMIT:  state_next = RUN;
      RUN:     if (cfg_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Word counter, shadow slots and the committed configuration.
  always_ff @(posedge clb_clk) begin
    if (rst) begin
      cfg_count <= '0;
      shadow    <= '0;
      prog_bus  <= '0;
    end else begin
      if (start_load)
        cfg_count <= '0;
      else if (xfer && word_ok)
        cfg_count <= cfg_count + CNT_W'(1);

      for (int unsigned k = 0; k < NUM_CLB; k++) begin
        if (xfer && word_ok && (cfg_count == CNT_W'(k)))
          shadow[k] <= cfg_data;
      end

      if (state == COMMIT)
        prog_bus <= shadow;
    end
  end

`ifdef CLB_CFG_PARITY_EN
  // Error pulse lands the cycle after the rejected transfer.
  always_ff @(posedge clb_clk) begin
    if (rst) cfg_error <= 1'b0;
    else     cfg_error <= bad_word;
  end
`else
  assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_clb_config_loader.sv
// Scoreboard bench for clb_config_loader: expected commits are queued by the driver and
// checked by a monitor whenever the array enters RUN. Parity tests need CLB_CFG_PARITY_EN.
module tb_clb_config_loader;

  localparam int unsigned NUM_CLB = 4;
  localparam int unsigned PROG_W  = 17;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned BUS_W   = NUM_CLB * PROG_W;

  localparam logic [BUS_W-1:0] CFG_A = {17'h00001, 17'h1FFFE, 17'h05555, 17'h1AAAA};
  localparam logic [BUS_W-1:0] CFG_B = {17'h15A5A, 17'h0ABCD, 17'h1F00F, 17'h00123};
  localparam logic [BUS_W-1:0] CFG_C = {17'h10000, 17'h00F0F, 17'h13579, 17'h02468};

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic              cfg_abort;
  logic [PROG_W-1:0] cfg_data;
  logic              cfg_valid;
`ifdef CLB_CFG_PARITY_EN
  logic              cfg_parity;
  logic              par_flip;
`endif
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_count;
  logic [BUS_W-1:0]  prog_bus;
  logic              clb_run;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_error;

  int checks = 0;
  int errors = 0;
  logic [BUS_W-1:0] exp_q[$];
  logic [BUS_W-1:0] cur_cfg;
  logic done_q = 1'b0;
  int busy_cnt = 0;
  int last_busy = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  clb_config_loader #(.NUM_CLB(NUM_CLB), .PROG_W(PROG_W), .CNT_W(CNT_W)) dut (
    .clb_clk   (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
`ifdef CLB_CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .cfg_ready (cfg_ready),
    .cfg_count (cfg_count),
    .prog_bus  (prog_bus),
    .clb_run   (clb_run),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every entry into RUN must match the oldest queued configuration.
  always @(negedge clk) begin
    if (cfg_done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got %0h expected no commit", prog_bus);
      end else begin
        check("commit_bus", 128'(prog_bus), 128'(exp_q.pop_front()));
        check("commit_run", 128'(clb_run), 128'(1));
      end
    end
    done_q = cfg_done;
    if (cfg_busy) busy_cnt++;
    else if (busy_cnt != 0) begin
      last_busy = busy_cnt;
      busy_cnt = 0;
    end
    if (cfg_error) err_pulses++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [PROG_W-1:0] d, input bit with_abort);
    int n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got cfg_ready 0 expected 1");
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_abort = with_abort;
`ifdef CLB_CFG_PARITY_EN
    cfg_parity = par_flip ^ ~(^d);
`endif
    tick();
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic load_all(input logic [BUS_W-1:0] cfg);
    exp_q.push_back(cfg);
    start_load();
    for (int i = 0; i < NUM_CLB; i++) send_word(cfg[i*PROG_W +: PROG_W], 1'b0);
    tick();
    cur_cfg = cfg;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 128'(cfg_ready), 128'(0));
    check({tag, "_count"}, 128'(cfg_count), 128'(0));
    check({tag, "_bus"},   128'(prog_bus),  128'(0));
    check({tag, "_run"},   128'(clb_run),   128'(0));
    check({tag, "_busy"},  128'(cfg_busy),  128'(0));
    check({tag, "_done"},  128'(cfg_done),  128'(0));
    check({tag, "_error"}, 128'(cfg_error), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
`ifdef CLB_CFG_PARITY_EN
    cfg_parity = 1'b0; par_flip = 1'b0;
`endif
    cur_cfg = '0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Back-to-back load of A with cycle-level latency checks.
    exp_q.push_back(CFG_A);
    start_load();
    check("t1_ready", 128'(cfg_ready), 128'(1));
    check("t1_count0", 128'(cfg_count), 128'(0));
    for (int i = 0; i < NUM_CLB; i++) send_word(CFG_A[i*PROG_W +: PROG_W], 1'b0);
    check("t1_commit_ready", 128'(cfg_ready), 128'(0));
    check("t1_commit_busy", 128'(cfg_busy), 128'(1));
    check("t1_commit_run", 128'(clb_run), 128'(0));
    check("t1_commit_count", 128'(cfg_count), 128'(NUM_CLB));
    tick();
    check("t1_run", 128'(clb_run), 128'(1));
    check("t1_done", 128'(cfg_done), 128'(1));
    check("t1_bus", 128'(prog_bus), 128'(CFG_A));
    check("t1_run_count", 128'(cfg_count), 128'(NUM_CLB));
    tick();
    check("t1_busy_len", 128'(last_busy), 128'(5));
    cur_cfg = CFG_A;

    // Reset from RUN clears the active configuration.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_run");

    // Valid toggling every other cycle.
    exp_q.push_back(CFG_A);
    start_load();
    for (int i = 0; i < NUM_CLB; i++) begin
      check("t2_count_pre", 128'(cfg_count), 128'(i));
      send_word(CFG_A[i*PROG_W +: PROG_W], 1'b0);
      if (i < NUM_CLB - 1) begin
        tick();
        check("t2_count_gap", 128'(cfg_count), 128'(i + 1));
      end
    end
    tick();
    check("t2_bus", 128'(prog_bus), 128'(CFG_A));
    cur_cfg = CFG_A;

    // Abort mid-load from RUN: old configuration stays, array stays stopped.
    start_load();
    check("t3_run_drop", 128'(clb_run), 128'(0));
    send_word(CFG_B[0 +: PROG_W], 1'b0);
    send_word(CFG_B[PROG_W +: PROG_W], 1'b0);
    send_word(CFG_B[2*PROG_W +: PROG_W], 1'b1);
    check("t3_idle_busy", 128'(cfg_busy), 128'(0));
    check("t3_idle_done", 128'(cfg_done), 128'(0));
    check("t3_idle_run", 128'(clb_run), 128'(0));
    check("t3_bus_kept", 128'(prog_bus), 128'(CFG_A));
    check("t3_count_held", 128'(cfg_count), 128'(2));

    // Abort coincident with the final word.
    start_load();
    check("t4_count_clr", 128'(cfg_count), 128'(0));
    for (int i = 0; i < NUM_CLB; i++) send_word(CFG_B[i*PROG_W +: PROG_W], i == NUM_CLB - 1);
    check("t4_busy", 128'(cfg_busy), 128'(0));
    check("t4_count_held", 128'(cfg_count), 128'(3));
    repeat (2) tick();
    check("t4_done", 128'(cfg_done), 128'(0));
    check("t4_bus_kept", 128'(prog_bus), 128'(CFG_A));
    load_all(CFG_B);
    check("t4_bus_b", 128'(prog_bus), 128'(CFG_B));

    // Reset in LOAD after three words, then a fresh load.
    start_load();
    for (int i = 0; i < 3; i++) send_word(CFG_C[i*PROG_W +: PROG_W], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_load");
    load_all(CFG_A);
    check("t5_bus", 128'(prog_bus), 128'(CFG_A));

`ifdef CLB_CFG_PARITY_EN
    // Bad parity on the second word aborts the load with one error pulse.
    start_load();
    send_word(CFG_C[0 +: PROG_W], 1'b0);
    par_flip = 1'b1;
    send_word(CFG_C[PROG_W +: PROG_W], 1'b0);
    par_flip = 1'b0;
    check("par_error", 128'(cfg_error), 128'(1));
    check("par_busy", 128'(cfg_busy), 128'(0));
    check("par_count", 128'(cfg_count), 128'(1));
    tick();
    check("par_error_clr", 128'(cfg_error), 128'(0));
    check("par_bus_kept", 128'(prog_bus), 128'(CFG_A));
    load_all(CFG_C);
    check("par_retry_bus", 128'(prog_bus), 128'(CFG_C));
    repeat (2) tick();
    check("err_pulses", 128'(err_pulses), 128'(1));
`else
    repeat (2) tick();
    check("err_pulses", 128'(err_pulses), 128'(0));
`endif
    check("final_bus", 128'(prog_bus), 128'(cur_cfg));
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clb_config_loader.md
Name: clb_config_loader

Overview:
- Configuration sequencer for an array of NUM_CLB CLBs.
- Accepts 17-bit programming words over a valid/ready stream and collects them into shadow registers.
- Commits the full set atomically to the flattened prog bus that drives every CLB. Bit 0 of each word is the mux select; bits 16:1 are the LUT truth table.
- Gates CLB operation through clb_run, so no CLB ever evaluates with a partially written configuration.

Parameters:
- NUM_CLB, 4, number of CLBs configured; must be >= 1.
- PROG_W, 17, width of one CLB programming word.
- CNT_W, $clog2(NUM_CLB+1), width of the word counter.

Ports:
- clb_clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  one-cycle request to begin a configuration load.
- cfg_abort  input  1  cancels a load in progress.
- cfg_data  input  PROG_W  programming word for the CLB at index cfg_count.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts a word this cycle.
- cfg_count  output  CNT_W  number of words accepted in the current load.
- prog_bus  output  NUM_CLB*PROG_W  active configuration; CLB k uses bits [k*PROG_W +: PROG_W].
- clb_run  output  1  CLB array enabled (clock-enable for CLB flops).
- cfg_busy  output  1  high in LOAD and COMMIT.
- cfg_done  output  1  high while in RUN.
- cfg_error  output  1  one-cycle pulse on rejected word (parity feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock, clb_clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; prog_bus, shadow registers and cfg_count = 0; cfg_ready, clb_run, cfg_busy, cfg_done and cfg_error = 0.
- Reset mid-LOAD or in RUN behaves identically to reset from IDLE; the active configuration is cleared.
- States: IDLE, LOAD, COMMIT, RUN. All outputs except prog_bus and cfg_error are decoded from state/counter.
- IDLE:
  - cfg_start=1 -> LOAD next cycle, cfg_count <= 0.
  - Otherwise stay.
- LOAD:
  - cfg_ready=1.
  - Transfer occurs when cfg_valid & cfg_ready. Word is written to shadow slot cfg_count, then cfg_count increments.
  - Transfer with cfg_count == NUM_CLB-1 -> COMMIT next cycle.
  - cfg_start is ignored in LOAD.
  - cfg_abort=1 -> IDLE next cycle. Shadow is discarded, prog_bus is unchanged, no word is accepted that cycle. Abort wins over a simultaneous transfer, including the final transfer.
- COMMIT:
  - Lasts one cycle; cfg_ready=0.
  - prog_bus <= shadow. Next state RUN.
  - cfg_abort is ignored in COMMIT.
- RUN:
  - clb_run=1, cfg_done=1.
  - cfg_start=1 -> LOAD next cycle. clb_run drops on that cycle; prog_bus holds the old configuration until the next COMMIT.
  - cfg_abort is ignored in RUN.
- Latency: if cfg_start is sampled at cycle t, cfg_ready=1 at t+1. If the last word transfers at cycle u, state is COMMIT at u+1, and the new prog_bus plus clb_run=1 are visible at u+2.
- With back-to-back valid, a full load takes NUM_CLB+2 cycles from cfg_start to RUN.
- cfg_count is NUM_CLB during COMMIT and RUN. It is held on entry to IDLE after an abort and cleared on the next cfg_start.

Optional Feature:
- Macro: CLB_CFG_PARITY_EN.
- When defined:
  - Adds input cfg_parity (1 bit); odd parity over {cfg_parity, cfg_data} is required.
  - A transfer with bad parity is not stored, and cfg_error pulses for one cycle the cycle after the transfer.
  - The state machine returns to IDLE, shadow is discarded, and prog_bus is unchanged.
- When not defined: the port is absent, cfg_error is tied to 0, and every transfer is accepted.

Test Plan:
- Reset, then NUM_CLB=4 back-to-back words 0x1AAAA, 0x05555, 0x1FFFE, 0x00001 -> prog_bus = {0x00001,0x1FFFE,0x05555,0x1AAAA}; clb_run=1 exactly 2 cycles after the 4th transfer; cfg_busy high for 5 cycles.
- Load with cfg_valid toggling every other cycle -> only words with valid&ready are stored, in order; cfg_count steps 0..4; result is identical to the first test.
- From RUN with config A, cfg_start then 2 words then cfg_abort -> clb_run=0 from the cycle after cfg_start, IDLE follows, prog_bus still equals A, cfg_done=0.
- cfg_abort asserted in the same cycle as the 4th word -> no COMMIT, prog_bus unchanged, state IDLE.
- rst asserted in LOAD after 3 words -> next cycle all outputs 0; a fresh load then completes normally.
- CLB_CFG_PARITY_EN defined, 2nd word with wrong parity -> cfg_error pulses once, state IDLE, prog_bus unchanged; a retry with correct parity succeeds.
